// File: rtl/vedic_seq_mult_ctrl_if.sv
// Operand/result handshake bundle for the sequential
// vedic multiplier controller.
interface vedic_seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] c;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/vedic_seq_mult_ctrl.sv
// Area-lean WIDTH x WIDTH multiplier: one 2x2 vedic cell
// walked over every digit pair with shift-accumulate.
module vedic_2_x_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t_lo, t_x0, t_x1, t_hi, cy;

  assign t_lo = a[0] & b[0];
  assign t_x0 = a[1] & b[0];
  assign t_x1 = a[0] & b[1];
  assign t_hi = a[1] & b[1];
  assign cy   = t_x0 & t_x1;
  assign p[0] = t_lo;
  assign p[1] = t_x0 ^ t_x1;
  assign p[2] = t_hi ^ cy;
  assign p[3] = t_hi & cy;
endmodule

module vedic_seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  vedic_seq_mult_ctrl_if.slave bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    c_q, c_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;

  logic [1:0]    da, db;
  logic [3:0]    p;
  logic [IW:0]   dsum;
  logic [PW-1:0] term;
  logic [PW-1:0] sum;

  assign da = a_q[{i_q, 1'b0} +: 2];
  assign db = b_q[{j_q, 1'b0} +: 2];

  vedic_2_x_2 u_cell (
    .a (da),
    .b (db),
    .p (p)
  );

  // digit weight of pair (i,j) is 4^(i+j)
  assign dsum = (IW+1)'(i_q) + (IW+1)'(j_q);
  assign term = PW'(p) << {dsum, 1'b0};
  assign sum  = acc_q + term;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_CALC;
        end
      end
      (state_q == S_CALC): begin
        acc_d = sum;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            c_d     = sum;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      (state_q == S_DONE): begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.c         = c_q;
endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Directed and random checks of the sequential
// vedic multiplier controller at WIDTH=8.
module tb_vedic_seq_mult_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc[$];

  always #5 clk = ~clk;

  vedic_seq_mult_ctrl_if #(.WIDTH(W)) bus ();

  vedic_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.in_valid && bus.in_ready)
      acc_cyc.push_back(cyc);
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_c;
    int          gap;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic [7:0] a, logic [7:0] b,
                    logic [15:0] exp, int gap, int hold,
                    string tag);
    int n;
    logic [15:0] c0;
    bus.out_ready = (hold == 0);
    for (int k = 0; k < gap; k++) begin
      tick();
      chk({tag, "_idle_ov"}, 32'(bus.out_valid), 0);
    end
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 16);
    chk({tag, "_c"}, 32'(bus.c), 32'(exp));
    c0 = bus.c;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (k == hold - 1) begin
        chk({tag, "_hold_ov"}, 32'(bus.out_valid), 1);
        chk({tag, "_hold_c"}, 32'(bus.c), 32'(c0));
        chk({tag, "_hold_rdy"}, 32'(bus.in_ready), 0);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 0);
    chk({tag, "_ret_rdy"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int n;
    int k;
    logic [15:0] exp2[2];
    logic [7:0]  ra, rb;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 0, 0};
    vecs[1] = '{8'h0D, 8'h0B, 16'h008F, 1, 0};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000, 0, 0};
    vecs[3] = '{8'h01, 8'hFF, 16'h00FF, 2, 0};
    vecs[4] = '{8'hFF, 8'h01, 16'h00FF, 0, 1};
    vecs[5] = '{8'h80, 8'h80, 16'h4000, 0, 0};
    vecs[6] = '{8'hAA, 8'h55, 16'h3872, 3, 2};
    vecs[7] = '{8'h0F, 8'hF0, 16'h0E10, 0, 0};
    vecs[8] = '{8'h12, 8'h34, 16'h03A8, 0, 5};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_c", 32'(bus.c), 0);

    foreach (vecs[v])
      op(vecs[v].a, vecs[v].b, vecs[v].exp_c,
         vecs[v].gap, vecs[v].hold, $sformatf("vec%0d", v));

    // backpressure with a pending second operand
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    tick();
    bus.a = 8'h77;
    bus.b = 8'h01;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_lat", 32'(n), 16);
    for (int q = 0; q < 5; q++) begin
      tick();
      chk("bp_c", 32'(bus.c), 32'h03A8);
      chk("bp_ov", 32'(bus.out_valid), 1);
      chk("bp_rdy", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_2nd_busy", 32'(bus.busy), 1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_2nd_lat", 32'(n), 16);
    chk("bp_2nd_c", 32'(bus.c), 32'h0077);
    tick();

    // reset in the middle of a calculation
    bus.in_valid = 1'b1;
    bus.a = 8'hAB;
    bus.b = 8'hCD;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rdy", 32'(bus.in_ready), 1);
    chk("mid_rst_ov", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_c", 32'(bus.c), 0);
    repeat (20) begin
      tick();
      chk("mid_rst_no_ov", 32'(bus.out_valid), 0);
    end
    op(8'h03, 8'h03, 16'h0009, 0, 0, "post_rst");

    // back-to-back with out_ready tied high
    acc_cyc.delete();
    exp2[0] = 16'h08A3;
    exp2[1] = 16'h0444;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 8'h21;
    bus.b = 8'h43;
    tick();
    bus.a = 8'h9C;
    bus.b = 8'h07;
    k = 0;
    for (int q = 0; q < 40; q++) begin
      tick();
      if (acc_cyc.size() >= 2) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (k < 2) chk("b2b_c", 32'(bus.c), 32'(exp2[k]));
        k++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_results", 32'(k), 2);
    chk("b2b_accepts", 32'(acc_cyc.size()), 2);
    if (acc_cyc.size() >= 2)
      chk("b2b_interval", 32'(acc_cyc[1] - acc_cyc[0]), 18);

    // random operands and handshake gaps
    for (int r = 0; r < 1000; r++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op(ra, rb, 16'(ra) * 16'(rb),
         $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
